mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, 32, address width.
REQ-002 Parameter DW, 32, data width.
REQ-003 Parameter STARVE_MAX, 4, consecutive data grants allowed while fetch waits (fairness build only).
REQ-004 The ports SHALL be, clock and reset first: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  instruction fetch request, held until if_valid
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched word
- if_valid  out  1  one-cycle fetch completion pulse
- d_read  in  1  data read request (driven by the decoded memRead), held until d_valid
- d_write  in  1  data write request (driven by the decoded memwrite), held until d_valid
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data
- d_valid  out  1  one-cycle data completion pulse
- mem_req  out  1  memory transaction active
- mem_we  out  1  write strobe, qualified by mem_req
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes current transaction this cycle
- stall_if  out  1  freeze fetch stage
- stall_mem  out  1  freeze pipeline at MEM stage and upstream

Function
REQ-005 The FSM SHALL have states IDLE, FETCH and DATA.
REQ-006 The arbitration point (IDLE, or FETCH/DATA with mem_ready=1) SHALL grant data when d_read|d_write, else fetch when if_req, else enter IDLE.
REQ-007 On grant, mem_addr, mem_wdata and mem_we SHALL be registered from the winner; mem_req SHALL be high from the next cycle until mem_ready is sampled high.
REQ-008 mem_addr, mem_we and mem_wdata SHALL stay stable while mem_req=1 and mem_ready=0.
REQ-009 d_read=d_write=1 together SHALL be performed as a write only.
REQ-010 On mem_ready in FETCH, if_rdata SHALL capture mem_rdata and if_valid SHALL pulse the next cycle; in DATA, d_valid SHALL pulse the next cycle; d_rdata SHALL capture mem_rdata for reads only and hold its value for writes.
REQ-011 Latency: request at cycle N with mem_ready at the first mem_req cycle SHALL give valid at N+2; back-to-back grants SHALL add no idle cycle.
REQ-012 stall_if SHALL equal if_req & ~if_valid, and stall_mem SHALL equal (d_read|d_write) & ~d_valid, combinationally.
REQ-013 A request dropped mid-transaction SHALL still complete; its valid pulse SHALL still occur.
REQ-014 mem_ready while mem_req=0 SHALL be ignored.

Reset
REQ-015 rst_n low SHALL force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_valid=0, d_valid=0, if_rdata=0 and d_rdata=0 immediately; any in-flight transaction SHALL be abandoned without a valid pulse.

Configuration
REQ-016 With MEM_ARB_FAIR_EN defined, a counter SHALL count data grants made while if_req=1, SHALL clear on any fetch grant, and when it equals STARVE_MAX the next arbitration SHALL grant fetch even if data is pending.
REQ-017 Without MEM_ARB_FAIR_EN, data SHALL have strict priority and no counter logic SHALL exist.

Structure
REQ-018 The state encoding and the default AW and DW constants SHALL live in the shared package mem_arb_pkg.
REQ-019 The starvation counter SHALL be the sub-module mem_arb_starve_cnt, instantiated only under MEM_ARB_FAIR_EN.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Fetch only: if_req=1, if_addr=0x40, mem_ready after 3 cycles, mem_rdata=0x1234 -> if_valid pulse with if_rdata=0x1234, stall_if=1 until then.
- Simultaneous: if_req=1 and d_read=1 at d_addr=0x100 -> DATA granted first, d_valid precedes if_valid, mem_addr sequence 0x100 then fetch address.
- Store: d_write=1, d_addr=0x8, d_wdata=0xDEAD -> mem_we=1 and mem_wdata=0xDEAD stable until mem_ready; d_rdata unchanged.
- Read+write conflict: d_read=d_write=1 -> single transaction with mem_we=1.
- Reset mid-DATA: rst_n low while mem_req=1 -> mem_req=0 asynchronously, no d_valid, IDLE after release.
- Fairness (MEM_ARB_FAIR_EN, STARVE_MAX=4): continuous data requests plus if_req -> fetch granted after the 4th data grant; without the macro fetch is never granted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
// Latency: n/a (types, constants and a pure grant-selection function only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int unsigned MEM_ARB_AW         = 32;
  localparam int unsigned MEM_ARB_DW         = 32;
  localparam int unsigned MEM_ARB_STARVE_MAX = 4;

  // Which requester currently owns the memory port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } arb_state_e;

  // Outcome of one arbitration decision.
  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_FETCH = 2'd1,
    GNT_DATA  = 2'd2
  } arb_gnt_e;

  // Data wins unless fetch is being forced after a long data streak.
  function automatic arb_gnt_e arb_pick(input logic data_pend,
                                        input logic fetch_pend,
                                        input logic fetch_force);
    arb_gnt_e res;
    res = GNT_NONE;
    if (fetch_force && fetch_pend) begin
      res = GNT_FETCH;
    end else if (data_pend) begin
      res = GNT_DATA;
    end else if (fetch_pend) begin
      res = GNT_FETCH;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Counts data grants issued while a fetch is waiting; flags when fetch must win.
// Latency: starve_o reflects grants made up to the previous clock edge.
// Backpressure: none; cleared by any fetch grant, saturates at STARVE_MAX.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = MEM_ARB_STARVE_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data_gnt_i,
  input  logic fetch_gnt_i,
  input  logic fetch_wait_i,
  output logic starve_o
);

  localparam int unsigned     CW      = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: reset on fetch service, advance on each data grant that makes fetch wait.
  always_comb begin
    cnt_d = cnt_q;
    if (fetch_gnt_i) begin
      cnt_d = '0;
    end else if (data_gnt_i && fetch_wait_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store; optional fairness under MEM_ARB_FAIR_EN.
// Latency: request in cycle N, mem_ready in first mem_req cycle -> valid pulse in N+2; back-to-back grants add no bubble.
// Backpressure: mem_ready low holds the transaction with stable address/data; requesters see stall_if / stall_mem.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = MEM_ARB_AW,
  parameter int unsigned DW         = MEM_ARB_DW,
  parameter int unsigned STARVE_MAX = MEM_ARB_STARVE_MAX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_read,
  input  logic          d_write,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall_if,
  output logic          stall_mem
);

  arb_state_e    state_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          if_valid_q;
  logic          d_valid_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;

  logic     data_pend;
  logic     fetch_pend;
  logic     done_fetch;
  logic     done_data;
  logic     arb_en;
  logic     fetch_force;
  arb_gnt_e gnt;

  // A read+write pair is one request; the write flag decides the direction at grant time.
  assign data_pend  = d_read | d_write;
  assign fetch_pend = if_req;

  // mem_ready only counts while a transaction is outstanding, so IDLE ignores it.
  assign done_fetch = (state_q == ST_FETCH) & mem_ready;
  assign done_data  = (state_q == ST_DATA) & mem_ready;
  assign arb_en     = (state_q == ST_IDLE) | done_fetch | done_data;

  assign gnt = arb_pick(data_pend, fetch_pend, fetch_force);

`ifdef MEM_ARB_FAIR_EN
  logic data_gnt;
  logic fetch_gnt;

  assign data_gnt  = arb_en & (gnt == GNT_DATA);
  assign fetch_gnt = arb_en & (gnt == GNT_FETCH);

  mem_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_gnt_i   (data_gnt),
    .fetch_gnt_i  (fetch_gnt),
    .fetch_wait_i (if_req),
    .starve_o     (fetch_force)
  );
`else
  // Strict data priority: fetch is never forced ahead of pending data.
  assign fetch_force = 1'b0;

  // The starvation window only matters to the fair build; a zero window has no useful meaning in either.
  if (STARVE_MAX == 0) begin : g_zero_starve_window
  end
`endif

  // Port-ownership FSM with registered memory-side and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_valid_q <= done_fetch;
      d_valid_q  <= done_data;
      if (done_fetch) begin
        if_rdata_q <= mem_rdata;
      end
      // Stores leave the last load value in place.
      if (done_data && !mem_we_q) begin
        d_rdata_q <= mem_rdata;
      end
      if (arb_en) begin
        unique case (gnt)
          GNT_DATA: begin
            state_q     <= ST_DATA;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_write;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
          end
          GNT_FETCH: begin
            state_q    <= ST_FETCH;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= if_addr;
          end
          default: begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  // Stalls release in the same cycle the completion pulse is visible.
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = data_pend & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// A bench-side memory responder completes each transaction after a configurable wait.
module tb_mem_port_arbiter;

  localparam int STARVE = 4;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;

  mem_port_arbiter #(
    .AW         (32),
    .DW         (32),
    .STARVE_MAX (STARVE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one outstanding transaction) ----------------
  bit          m_busy, m_data, m_we, m_ifv, m_dv;
  logic [31:0] m_addr, m_wdata, m_ifr, m_dr;
  int          m_cyc, m_starve;
  logic        m_fin, m_take_f;

  assign m_fin    = m_busy && mem_ready;
  assign m_take_f = if_req && (!(d_read || d_write) || (FAIR && m_starve == STARVE));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_data   <= 1'b0;
      m_we     <= 1'b0;
      m_ifv    <= 1'b0;
      m_dv     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_ifr    <= '0;
      m_dr     <= '0;
      m_cyc    <= 0;
      m_starve <= 0;
    end else begin
      m_ifv <= m_fin && !m_data;
      m_dv  <= m_fin && m_data;
      if (m_fin && !m_data) m_ifr <= mem_rdata;
      if (m_fin && m_data && !m_we) m_dr <= mem_rdata;
      if (!m_busy || m_fin) begin
        m_cyc <= 0;
        if (m_take_f) begin
          m_busy   <= 1'b1;
          m_data   <= 1'b0;
          m_we     <= 1'b0;
          m_addr   <= if_addr;
          m_starve <= 0;
        end else if (d_read || d_write) begin
          m_busy  <= 1'b1;
          m_data  <= 1'b1;
          m_we    <= d_write;
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
          if (if_req) m_starve <= m_starve + 1;
        end else begin
          m_busy <= 1'b0;
          m_we   <= 1'b0;
        end
      end else begin
        m_cyc <= m_cyc + 1;
      end
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clk) begin
    chk("mem_req", 32'(mem_req), 32'(m_busy));
    chk("mem_we", 32'(mem_we & mem_req), 32'(m_busy & m_we));
    if (m_busy) chk("mem_addr", mem_addr, m_addr);
    if (m_busy && m_we) chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_valid", 32'(if_valid), 32'(m_ifv));
    chk("d_valid", 32'(d_valid), 32'(m_dv));
    chk("if_rdata", if_rdata, m_ifr);
    chk("d_rdata", d_rdata, m_dr);
    chk("stall_if", 32'(stall_if), 32'(if_req & ~m_ifv));
    chk("stall_mem", 32'(stall_mem), 32'((d_read | d_write) & ~m_dv));
  end

  // ---------------- stimulus ----------------
  int lat;
  bit keep_if, keep_d, spur;

  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    if (a == 32'h40) return 32'h0000_1234;
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  // Advance one cycle; the memory responder completes after 'lat' wait cycles
  // and the owning requester lowers its request in the completing cycle.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      mem_ready = (m_busy && m_cyc == lat) || (!m_busy && spur);
      mem_rdata = m_busy ? rdata_for(m_addr) : 32'hFFFF_FFFF;
      if (m_busy && m_cyc == lat) begin
        if (m_data && !keep_d) begin
          d_read  = 1'b0;
          d_write = 1'b0;
        end
        if (!m_data && !keep_if) if_req = 1'b0;
      end
    end
  endtask

  int f_cnt, f_first, mf_cnt, dv_cnt;

  initial begin
    rst_n = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    lat = 0; keep_if = 1'b0; keep_d = 1'b0; spur = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst mem_req", 32'(mem_req), 32'h0);
    chk("rst mem_we", 32'(mem_we), 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst valids", 32'({if_valid, d_valid}), 32'h0);
    chk("rst if_rdata", if_rdata, 32'h0);
    chk("rst d_rdata", d_rdata, 32'h0);
    rst_n = 1'b1;
    step(2);

    // Fetch only, three wait cycles
    lat = 3; if_req = 1'b1; if_addr = 32'h40;
    step(1);
    chk("fo mem_addr", mem_addr, 32'h40);
    chk("fo stall_if", 32'(stall_if), 32'h1);
    step(3);
    chk("fo no early valid", 32'(if_valid), 32'h0);
    step(1);
    chk("fo if_valid", 32'(if_valid), 32'h1);
    chk("fo if_rdata", if_rdata, 32'h0000_1234);
    chk("fo model rdata", m_ifr, 32'h0000_1234);
    step(1);
    chk("fo pulse ends", 32'(if_valid), 32'h0);
    step(2);

    // Simultaneous fetch and load, zero wait: data first, no bubble, valid at N+2
    lat = 0; if_req = 1'b1; if_addr = 32'h44; d_read = 1'b1; d_addr = 32'h100;
    step(1);
    chk("sim first addr", mem_addr, 32'h100);
    step(1);
    chk("sim d_valid N+2", 32'(d_valid), 32'h1);
    chk("sim d_rdata", d_rdata, 32'hA4A5_0100);
    chk("sim second addr", mem_addr, 32'h44);
    chk("sim if_valid later", 32'(if_valid), 32'h0);
    step(1);
    chk("sim if_valid", 32'(if_valid), 32'h1);
    chk("sim if_rdata", if_rdata, 32'hA5E1_0044);
    step(2);

    // Store with two wait cycles; inputs change after grant, port must not
    lat = 2; d_write = 1'b1; d_addr = 32'h8; d_wdata = 32'h0000_DEAD;
    step(1);
    d_addr = 32'hC; d_wdata = 32'h0000_BEEF;
    chk("st mem_we", 32'(mem_we), 32'h1);
    step(2);
    chk("st wdata held", mem_wdata, 32'h0000_DEAD);
    chk("st addr held", mem_addr, 32'h8);
    step(1);
    chk("st d_valid", 32'(d_valid), 32'h1);
    chk("st d_rdata kept", d_rdata, 32'hA4A5_0100);
    step(2);

    // Read+write together: one write transaction
    lat = 0; d_read = 1'b1; d_write = 1'b1; d_addr = 32'h20; d_wdata = 32'h5A5A;
    step(1);
    chk("rw mem_we", 32'(mem_we), 32'h1);
    step(1);
    chk("rw d_valid", 32'(d_valid), 32'h1);
    chk("rw single txn", 32'(mem_req), 32'h0);
    chk("rw d_rdata kept", d_rdata, 32'hA4A5_0100);
    step(1);

    // mem_ready while idle is ignored
    spur = 1'b1;
    step(3);
    chk("spur mem_req", 32'(mem_req), 32'h0);
    chk("spur valids", 32'({if_valid, d_valid}), 32'h0);
    spur = 1'b0;
    step(1);

    // Fetch request dropped right after grant still completes
    lat = 2; if_req = 1'b1; if_addr = 32'h80;
    step(1);
    if_req = 1'b0;
    step(3);
    chk("drop if_valid", 32'(if_valid), 32'h1);
    chk("drop if_rdata", if_rdata, 32'hA525_0080);
    step(2);

    // Asynchronous reset in the middle of a load
    lat = 5; d_read = 1'b1; d_addr = 32'h30;
    step(2);
    chk("rm busy", 32'(mem_req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rm async mem_req", 32'(mem_req), 32'h0);
    chk("rm async mem_addr", mem_addr, 32'h0);
    d_read = 1'b0;
    step(1);
    rst_n = 1'b1;
    dv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (d_valid) dv_cnt++;
    end
    chk("rm no d_valid", 32'(dv_cnt), 32'h0);
    chk("rm idle", 32'(mem_req), 32'h0);

    // Continuous data with a waiting fetch
    lat = 0; keep_d = 1'b1; d_read = 1'b1; d_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h300;
    f_cnt = 0; f_first = -1; mf_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (mem_req && mem_addr == 32'h300) begin
        f_cnt++;
        if (f_first < 0) f_first = i;
      end
      if (m_busy && m_addr == 32'h300) mf_cnt++;
    end
    chk("fair fetch count", 32'(f_cnt), FAIR ? 32'd1 : 32'd0);
    chk("fair fetch cycle", 32'(f_first), FAIR ? 32'd5 : 32'hFFFF_FFFF);
    chk("fair model count", 32'(mf_cnt), FAIR ? 32'd1 : 32'd0);
    keep_d = 1'b0; d_read = 1'b0; if_req = 1'b0;
    step(3);
    chk("end idle", 32'(mem_req), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
